// File: rtl/stream_pkg.sv
// Shared types for the stream player: FSM state encoding and default sample width.
package stream_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } player_state_t;

endpackage

// File: rtl/stream_player_mem.sv
// Sample register file: one synchronous write port, one combinational read port.
module stream_player_mem
  import stream_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; loaded samples must survive a player reset, and a
  // reset-free array maps onto plain flops or distributed RAM without a clear network.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/stream_player.sv
// Replays a software-loaded sample sequence one sample per period onto a din-style bus,
// with optional inter-sample gap and looping.
module stream_player
  import stream_pkg::*;
#(
  parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int  DEPTH      = 16,
  parameter int  GAP_WIDTH  = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW:0]           len,
  input  logic [GAP_WIDTH-1:0]  gap,
  input  logic                  loop,
  input  logic                  start,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [AW:0]          LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]        IDX_ONE = AW'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

  player_state_t         state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [AW:0]           len_q, len_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  logic                  loop_q, loop_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  last;
  logic                  advance;
  logic [AW-1:0]         nxt_idx;

  stream_player_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_en && !busy_q),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Wrap is an explicit compare against len_q-1 so any len, not just DEPTH, loops cleanly.
  assign last    = ({1'b0, idx_q} == (len_q - LEN_ONE));
  assign nxt_idx = last ? '0 : idx_q + IDX_ONE;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_cnt_d    = gap_cnt_q;
    len_d        = len_q;
    gap_d        = gap_q;
    loop_d       = loop_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    advance      = 1'b0;
    rd_addr      = (state_q == IDLE) ? '0 : nxt_idx;

    if (abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              len_d        = len;
              gap_d        = gap;
              loop_d       = loop;
              idx_d        = '0;
              dout_d       = rd_data;
              dout_valid_d = 1'b1;
              busy_d       = 1'b1;
              state_d      = PLAY;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        PLAY: begin
          if (gap_q != '0) begin
            gap_cnt_d = gap_q - GAP_ONE;
            state_d   = GAP;
          end else begin
            advance = 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt_q == '0) advance = 1'b1;
          else                 gap_cnt_d = gap_cnt_q - GAP_ONE;
        end
        default: state_d = IDLE;
      endcase

      // The edge that would issue the next sample either issues it or retires the run.
      if (advance) begin
        if (last && !loop_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d        = nxt_idx;
          dout_d       = rd_data;
          dout_valid_d = 1'b1;
          state_d      = PLAY;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      gap_cnt_q    <= '0;
      len_q        <= '0;
      gap_q        <= '0;
      loop_q       <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      gap_cnt_q    <= gap_cnt_d;
      len_q        <= len_d;
      gap_q        <= gap_d;
      loop_q       <= loop_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
